// File: rtl/comet_ii_pkg.sv
// Shared COMET II bus definitions: word width, responder state encoding and
// bus direction constants.
package comet_ii_pkg;

    localparam int WORD_W = 16;

    // 3-bit encoding keeps the responder state the same width as the core FSM.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RESP = 3'd2
    } resp_state_e;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

endpackage

// File: rtl/comet_ii_ram.sv
// Single-port synchronous word RAM with one write port and a registered read port.
// Contents are intentionally not reset.
module comet_ii_ram
    import comet_ii_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              mclk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              rd_en_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rd_q;

    // Write and registered read share the single address port.
    always_ff @(posedge mclk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rd_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/comet_ii_mem_responder.sv
// Memory-side responder for the COMET II core bus: single-word reads/writes,
// programmable read wait states, out-of-range flagging.
//
// state  | meaning
// S_IDLE | waiting for req; captures we/addr/wdata on the request edge
// S_WAIT | read wait states; counter runs WAIT_CYC-1 down to 0
// S_RESP | final cycle; ack/err/rdata registered on the edge leaving it
module comet_ii_mem_responder
    import comet_ii_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [15:0]       addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam logic       HAS_WAIT  = (WAIT_CYC > 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    resp_state_e       state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              rerr_q;
    logic [3:0]        cnt_q;
    logic              ack_q;
    logic              err_q;
    logic [WORD_W-1:0] rdata_q;

    logic              in_idle;
    logic              range_err;
    logic              go_wait;
    logic              enter_resp;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_rdata;

    assign in_idle    = (state_q == S_IDLE);
    assign range_err  = ((addr_i >> ADDR_W) != 16'h0000);
    assign go_wait    = in_idle && req_i && (we_i == RD) && !range_err && HAS_WAIT;
    assign enter_resp = (in_idle && req_i && !go_wait) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));

    // The RAM read is launched on the edge entering S_RESP; only valid reads
    // ever pass through S_WAIT, so the direction/range test applies in S_IDLE.
    assign ram_rd_en  = enter_resp && (in_idle ? ((we_i == RD) && !range_err) : 1'b1);
    // Writes commit on the ack-raising edge from the captured request, so a
    // reset during S_RESP drops the write along with its ack.
    assign ram_wr_en  = (state_q == S_RESP) && (we_q == WR) && !rerr_q;
    assign ram_addr   = in_idle ? addr_i[ADDR_W-1:0] : addr_q;

    comet_ii_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .mclk    (mclk),
        .addr_i  (ram_addr),
        .wr_en_i (ram_wr_en),
        .wdata_i (ram_ram_wdata_sel()),
        .rd_en_i (ram_rd_en),
        .rdata_o (ram_rdata)
    );

    function automatic logic [WORD_W-1:0] ram_ram_wdata_sel();
        return wdata_q;
    endfunction

    // Responder FSM with request capture, wait counter and registered outputs.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= RD;
            addr_q  <= '0;
            wdata_q <= '0;
            rerr_q  <= 1'b0;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i[ADDR_W-1:0];
                        wdata_q <= wdata_i;
                        rerr_q  <= range_err;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= go_wait ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    ack_q <= 1'b1;
                    err_q <= rerr_q;
                    if (we_q == RD) begin
                        rdata_q <= rerr_q ? '0 : ram_rdata;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign busy_o  = !in_idle;

endmodule
